// File: rtl/mcu_spi_sync.sv
// Single-clock SPI slave: pins are oversampled in clk, the first byte of a frame
// selects a byte target, following bytes are strobed to it and its read byte is shifted out.
module mcu_spi_sync #(
   parameter int N_TARGETS   = 4,
   parameter int SPI_MODE    = 1,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     spi_ss,
   input  logic                     spi_clk,
   input  logic                     spi_din,
   output logic                     spi_dout,
   input  logic [8*N_TARGETS-1:0]   tgt_din,
   output logic [N_TARGETS-1:0]     tgt_strobe,
   output logic                     tgt_start,
   output logic [7:0]               mcu_dout,
   output logic                     frame_end,
   output logic [CNT_W-1:0]         byte_cnt,
   output logic                     bad_target
);

   // state  | meaning
   // IDLE   | select inactive, waiting for ss falling
   // TARGET | receiving the target-ID byte, MISO held at 0
   // DATA   | receiving data bytes for the latched target
   typedef enum logic [1:0] {S_IDLE, S_TARGET, S_DATA} state_t;

   localparam bit CPOL        = ((SPI_MODE / 2) % 2) == 1;
   localparam bit CPHA        = (SPI_MODE % 2) == 1;
   localparam bit SAMPLE_RISE = (CPOL == CPHA);

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] ss_sync, sck_sync, din_sync;
   logic                   ss_prev, sck_prev;
   logic                   ss_s, sck_s, din_s;
   logic                   ss_fall, ss_rise, sck_rise, sck_fall;
   logic                   samp_edge, setup_edge, samp_act, setup_act;
   logic                   frame_start, byte_end;
   logic [2:0]             bit_cnt;
   logic [6:0]             rx_sr;
   logic [7:0]             rx_byte, target, tgt_nx, rd_byte, tx_sr, data_byte;
   logic                   bad_nx, tx_load, tx_zero, tx_shift;
   logic                   data_done, first_pend;
   logic [N_TARGETS-1:0]   strobe_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ss_sync  <= '1;
         sck_sync <= {SYNC_STAGES{CPOL}};
         din_sync <= '0;
         ss_prev  <= 1'b1;
         sck_prev <= CPOL;
      end else begin
         ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
         din_sync <= {din_sync[SYNC_STAGES-2:0], spi_din};
         ss_prev  <= ss_sync[SYNC_STAGES-1];
         sck_prev <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign ss_s       = ss_sync[SYNC_STAGES-1];
   assign sck_s      = sck_sync[SYNC_STAGES-1];
   assign din_s      = din_sync[SYNC_STAGES-1];
   assign ss_fall    = ss_prev & ~ss_s;
   assign ss_rise    = ~ss_prev & ss_s;
   assign sck_rise   = ~sck_prev & sck_s;
   assign sck_fall   = sck_prev & ~sck_s;
   assign samp_edge  = SAMPLE_RISE ? sck_rise : sck_fall;
   assign setup_edge = SAMPLE_RISE ? sck_fall : sck_rise;

   // A select release in the same cycle as a clock edge cancels that edge.
   assign samp_act    = samp_edge & ~ss_rise & (state != S_IDLE);
   assign setup_act   = setup_edge & ~ss_rise & (state != S_IDLE);
   assign frame_start = (state == S_IDLE) & ss_fall;
   assign byte_end    = samp_act & (bit_cnt == 3'd7);
   assign rx_byte     = {rx_sr, din_s};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (ss_rise) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (ss_fall) state_nx = S_TARGET;
            S_TARGET: if (byte_end) state_nx = S_DATA;
            default:  state_nx = state;
         endcase
      end
   end

   // The target being latched this cycle already selects the first read byte (CPHA=0).
   assign tgt_nx = (state == S_TARGET && byte_end) ? rx_byte : target;
   assign bad_nx = (tgt_nx >= 8'(N_TARGETS));

   always_comb begin
      rd_byte   = 8'h00;
      strobe_nx = '0;
      for (int k = 0; k < N_TARGETS; k++) begin
         if (tgt_nx == 8'(k)) rd_byte = tgt_din[8*k +: 8];
         if (target == 8'(k)) strobe_nx[k] = 1'b1;
      end
   end

   assign tx_zero  = frame_start | (state == S_TARGET && !byte_end) | bad_nx;
   assign tx_load  = frame_start | (CPHA ? (setup_act && bit_cnt == 3'd0) : byte_end);
   assign tx_shift = setup_act & (bit_cnt != 3'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt    <= '0;
         rx_sr      <= '0;
         target     <= '0;
         bad_target <= 1'b0;
         byte_cnt   <= '0;
         data_done  <= 1'b0;
         data_byte  <= '0;
         first_pend <= 1'b0;
         tgt_strobe <= '0;
         tgt_start  <= 1'b0;
         mcu_dout   <= '0;
         frame_end  <= 1'b0;
         tx_sr      <= '0;
         spi_dout   <= 1'b0;
      end else begin
         if (frame_start || ss_rise) bit_cnt <= '0;
         else if (samp_act)          bit_cnt <= bit_cnt + 3'd1;

         if (samp_act) rx_sr <= rx_byte[6:0];

         if (frame_start || ss_rise) begin
            bad_target <= 1'b0;
         end else if (state == S_TARGET && byte_end) begin
            target     <= rx_byte;
            bad_target <= bad_nx;
         end

         if (frame_start)                            byte_cnt <= '0;
         else if (byte_end && byte_cnt != '1)        byte_cnt <= byte_cnt + CNT_W'(1);

         data_done <= byte_end & (state == S_DATA) & ~bad_target;
         if (byte_end) data_byte <= rx_byte;

         tgt_strobe <= '0;
         tgt_start  <= 1'b0;
         if (frame_start) first_pend <= 1'b1;
         if (data_done) begin
            tgt_strobe <= strobe_nx;
            tgt_start  <= first_pend;
            first_pend <= 1'b0;
            mcu_dout   <= data_byte;
         end

         frame_end <= ss_rise & (state != S_IDLE);

         if (tx_load)       tx_sr <= tx_zero ? 8'h00 : rd_byte;
         else if (tx_shift) tx_sr <= {tx_sr[6:0], 1'b0};

         spi_dout <= ~ss_s & tx_sr[7];
      end
   end

endmodule

// File: tb/tb_mcu_spi_sync.sv
// Bench for mcu_spi_sync: one instance per SPI mode, an SPI master model driving
// the pins, and a frame-level reference model for strobes, MISO and counters.
module tb_mcu_spi_sync;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] tgt_din;
   logic        ss_p [4];
   logic        sck_p [4];
   logic        mosi_p [4];
   logic        miso_w [4];
   logic [3:0]  strobe_w [4];
   logic        start_w [4];
   logic [7:0]  mdout_w [4];
   logic        fend_w [4];
   logic [7:0]  bc_w [4];
   logic        bad_w [4];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int CW = (g == 2) ? 2 : 8;
      logic [CW-1:0] bc;
      mcu_spi_sync #(.N_TARGETS(4), .SPI_MODE(g), .SYNC_STAGES(2), .CNT_W(CW)) dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .spi_ss     (ss_p[g]),
         .spi_clk    (sck_p[g]),
         .spi_din    (mosi_p[g]),
         .spi_dout   (miso_w[g]),
         .tgt_din    (tgt_din),
         .tgt_strobe (strobe_w[g]),
         .tgt_start  (start_w[g]),
         .mcu_dout   (mdout_w[g]),
         .frame_end  (fend_w[g]),
         .byte_cnt   (bc),
         .bad_target (bad_w[g])
      );
      assign bc_w[g] = 8'(bc);
   end

   // Strobe/frame_end monitor for the instance under test; activity elsewhere is stray.
   int         cur = 0;
   int         n_fend = 0;
   int         stray = 0;
   logic [7:0] obs_data [$];
   logic [3:0] obs_strb [$];
   logic       obs_start [$];

   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (d == cur) begin
            if (strobe_w[d] != 4'h0) begin
               obs_data.push_back(mdout_w[d]);
               obs_strb.push_back(strobe_w[d]);
               obs_start.push_back(start_w[d]);
            end
            if (fend_w[d]) n_fend++;
         end else if (strobe_w[d] != 4'h0 || fend_w[d]) begin
            stray++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_h(input int h);
      repeat (h) @(negedge clk);
   endtask

   task automatic ss_down(input int d, input int h);
      ss_p[d] = 1'b0;
      wait_h(h);
   endtask

   task automatic ss_up(input int d, input int h, output logic bad_seen);
      wait_h(h);
      bad_seen = bad_w[d];
      ss_p[d]  = 1'b1;
      wait_h(12);
   endtask

   // Master side of one byte (or of its first nbits), MSB first, per the mode of instance d.
   task automatic send_byte(input int d, input logic [7:0] b, input int nbits, input int h,
                            output logic [7:0] rx);
      logic cpol, cpha;
      cpol = ((d >> 1) & 1) == 1;
      cpha = (d & 1) == 1;
      rx   = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi_p[d] = b[7-i];
            wait_h(h);
            rx = {rx[6:0], miso_w[d]};
            sck_p[d] = ~cpol;
            wait_h(h);
            sck_p[d] = cpol;
         end else begin
            sck_p[d]  = ~cpol;
            mosi_p[d] = b[7-i];
            wait_h(h);
            rx = {rx[6:0], miso_w[d]};
            sck_p[d] = cpol;
            wait_h(h);
         end
      end
   endtask

   // Send a frame and compare everything against the frame-level model.
   task automatic run_frame(input int d, input logic [7:0] txb [$], input int last_bits,
                            input int h, input string tag);
      logic [7:0] rxb [$];
      logic [7:0] r, exp_b;
      logic       bad_seen;
      int sbase, fbase, t, ncomp, ndat, maxc, exp_ns, nb;
      cur   = d;
      sbase = obs_data.size();
      fbase = n_fend;
      ss_down(d, h);
      for (int i = 0; i < txb.size(); i++) begin
         nb = (i == txb.size() - 1) ? last_bits : 8;
         send_byte(d, txb[i], nb, h, r);
         rxb.push_back(r);
      end
      ss_up(d, h, bad_seen);

      t      = int'(txb[0]);
      ncomp  = (last_bits == 8) ? txb.size() : txb.size() - 1;
      ndat   = (ncomp > 0) ? ncomp - 1 : 0;
      maxc   = (d == 2) ? 3 : 255;
      exp_ns = (t < 4) ? ndat : 0;

      check({tag, " byte_cnt"}, 32'(bc_w[d]), 32'((ncomp < maxc) ? ncomp : maxc));
      check({tag, " bad_target"}, 32'(bad_seen), 32'(ncomp >= 1 && t >= 4));
      check({tag, " frame_end"}, 32'(n_fend - fbase), 32'd1);
      check({tag, " strobes"}, 32'(obs_data.size() - sbase), 32'(exp_ns));
      for (int i = 0; i < exp_ns && sbase + i < obs_data.size(); i++) begin
         check({tag, " strobe"}, 32'(obs_strb[sbase+i]), 32'(4'b0001 << t));
         check({tag, " mcu_dout"}, 32'(obs_data[sbase+i]), 32'(txb[i+1]));
         check({tag, " tgt_start"}, 32'(obs_start[sbase+i]), 32'(i == 0));
      end
      for (int i = 0; i < ncomp; i++) begin
         exp_b = (i == 0 || t >= 4) ? 8'h00 : tgt_din[8*t +: 8];
         check({tag, " miso"}, 32'(rxb[i]), 32'(exp_b));
      end
      check({tag, " miso_idle"}, 32'(miso_w[d]), 32'd0);
      if (exp_ns > 0) check({tag, " mcu_dout_hold"}, 32'(mdout_w[d]), 32'(txb[ndat]));
   endtask

   task automatic check_zero(input int d, input string tag);
      check({tag, " spi_dout"}, 32'(miso_w[d]), 32'd0);
      check({tag, " tgt_strobe"}, 32'(strobe_w[d]), 32'd0);
      check({tag, " tgt_start"}, 32'(start_w[d]), 32'd0);
      check({tag, " mcu_dout"}, 32'(mdout_w[d]), 32'd0);
      check({tag, " frame_end"}, 32'(fend_w[d]), 32'd0);
      check({tag, " byte_cnt"}, 32'(bc_w[d]), 32'd0);
      check({tag, " bad_target"}, 32'(bad_w[d]), 32'd0);
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] r;
      int fb, d, t, n, h;

      reset_n = 1'b0;
      tgt_din = 32'h0;
      for (int i = 0; i < 4; i++) begin
         ss_p[i]   = 1'b1;
         sck_p[i]  = (i >= 2);
         mosi_p[i] = 1'b0;
      end
      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) check_zero(i, "reset");
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Write frame to target 2 in mode 1.
      tgt_din = 32'h1122_3344;
      q = '{8'h02, 8'hA5, 8'h3C};
      run_frame(1, q, 8, 6, "write_m1");

      // Read path in every mode.
      tgt_din = 32'h0000_8100;
      for (int m = 0; m < 4; m++) begin
         q = '{8'h01, 8'h00, 8'h00};
         run_frame(m, q, 8, 6, "read");
      end

      tgt_din = 32'hFFFF_FFFF;
      q = '{8'h07, 8'h55};
      run_frame(1, q, 8, 6, "bad_target");

      q = '{8'h00, 8'hB7};
      run_frame(1, q, 5, 6, "partial");

      q = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      run_frame(2, q, 8, 6, "saturate");

      // Reset in the middle of a frame.
      cur = 1;
      fb  = n_fend;
      ss_down(1, 6);
      send_byte(1, 8'h01, 8, 6, r);
      send_byte(1, 8'hC3, 8, 6, r);
      send_byte(1, 8'hFF, 3, 6, r);
      check("pre_reset mcu_dout", 32'(mdout_w[1]), 32'hC3);
      check("pre_reset byte_cnt", 32'(bc_w[1]), 32'd2);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero(1, "mid_reset");
      ss_p[1]  = 1'b1;
      sck_p[1] = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_reset no frame_end", 32'(n_fend - fb), 32'd0);
      q = '{8'h01, 8'h5A, 8'hA5};
      run_frame(1, q, 8, 6, "post_reset");

      // Randomized frames, a third of them at the minimum half-period.
      for (int k = 0; k < 24; k++) begin
         d = k % 4;
         t = $urandom_range(0, 5);
         n = $urandom_range(1, 4);
         h = (k % 3 == 0) ? 5 : $urandom_range(5, 8);
         tgt_din = $urandom;
         q = '{};
         q.push_back(8'(t));
         for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
         run_frame(d, q, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8, h, "random");
      end

      check("stray events", 32'(stray), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
